// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of the UART transmitter: accepts bytes over valid/ready and
// hands them one at a time to the transmitter's start/busy/done interface.
module uart_tx_feeder #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [7:0]            i_data,
  output logic                  o_ready,
  input  logic                  i_flush,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_tx_start,
  output logic [7:0]            o_tx_data,
  input  logic                  i_tx_busy,
  input  logic                  i_tx_done,
  output logic                  o_idle
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = {(ADDR_WIDTH + 1){1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};

  localparam logic [3:0] S_IDLE      = 4'b0001;
  localparam logic [3:0] S_LAUNCH    = 4'b0010;
  localparam logic [3:0] S_WAIT_BUSY = 4'b0100;
  localparam logic [3:0] S_WAIT_DONE = 4'b1000;

  logic [7:0]            mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [3:0]            state_r;
  logic [3:0]            state_nxt_s;
  logic [7:0]            tx_data_r;
  logic                  push_s;
  logic                  pop_s;

  assign o_count    = count_r;
  assign o_empty    = (count_r == CNT_ZERO);
  assign o_full     = (count_r == DEPTH_C);
  assign o_ready    = !o_full && !i_flush;
  assign o_tx_start = (state_r == S_LAUNCH);
  assign o_tx_data  = tx_data_r;
  assign o_idle     = (state_r == S_IDLE) && o_empty && !i_tx_busy;

  // The busy guard keeps a start from being lost to a frame still in flight after reset.
  assign push_s = i_valid && o_ready;
  assign pop_s  = (state_r == S_IDLE) && !o_empty && !i_tx_busy && !i_flush;

  // Next-state decode; any non-one-hot encoding falls back to IDLE.
  always_comb begin
    state_nxt_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (pop_s) begin
          state_nxt_s = S_LAUNCH;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_LAUNCH: state_nxt_s = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_nxt_s = S_WAIT_DONE;
        end else begin
          state_nxt_s = S_WAIT_BUSY;
        end
      end
      S_WAIT_DONE: begin
        if (i_tx_done) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_WAIT_DONE;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Storage array; flush only moves the pointers, so contents need no clearing there.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= i_data;
    end
  end

  // Pointers and occupancy; flush overrides both push and pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (i_flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Transmit byte is captured only at a pop, so it is valid alongside the start pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_data_r <= 8'h00;
    end else if (pop_s) begin
      tx_data_r <= mem_r[rd_ptr_r];
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomised and directed bench for uart_tx_feeder against a queue-based model,
// with a small transmitter stub producing busy/done.
module tb_uart_tx_feeder;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid;
  logic [7:0]    data;
  logic          ready;
  logic          flush;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic          tx_done;
  logic          idle;

  always #5 clk = ~clk;

  uart_tx_feeder #(.ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data), .o_ready(ready),
    .i_flush(flush), .o_count(count), .o_empty(empty), .o_full(full),
    .o_tx_start(tx_start), .o_tx_data(tx_data), .i_tx_busy(tx_busy),
    .i_tx_done(tx_done), .o_idle(idle)
  );

  int n_vec = 0;
  int n_err = 0;

  // model: byte queue, launch progress (0 waiting, 1 starting, 2 awaiting busy, 3 awaiting done)
  logic [7:0] mq[$];
  int         m_phase;
  logic [7:0] m_last;

  logic [7:0] cap_q[$];
  logic       seen_start = 1'b0;
  int         stub_cnt = 0;
  int         frame_len = 3;
  bit         hold_busy = 1'b0;
  bit         inject_done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase = 0;
    m_last = 8'h00;
  endtask

  task automatic model_step();
    bit can_pop;
    bit accept;
    accept  = valid && (mq.size() < DEPTH) && !flush;
    can_pop = (m_phase == 0) && (mq.size() > 0) && !tx_busy && !flush;
    if (flush) begin
      mq.delete();
    end else begin
      if (can_pop) m_last = mq.pop_front();
      if (accept) mq.push_back(data);
    end
    case (m_phase)
      0: if (can_pop) m_phase = 1;
      1: m_phase = 2;
      2: if (tx_busy) m_phase = 3;
      3: if (tx_done) m_phase = 0;
      default: m_phase = 0;
    endcase
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    int sz;
    sz = mq.size();
    chk("count", int'(count), sz);
    chk("empty", int'(empty), int'(sz == 0));
    chk("full", int'(full), int'(sz == DEPTH));
    chk("ready", int'(ready), int'(sz < DEPTH && !flush));
    chk("tx_start", int'(tx_start), int'(m_phase == 1));
    chk("tx_data", int'(tx_data), int'(m_last));
    chk("idle", int'(idle), int'(m_phase == 0 && sz == 0 && !tx_busy));
    seen_start = tx_start;
    if (tx_start) cap_q.push_back(tx_data);
  end

  task automatic tick();
    bit nb;
    bit nd;
    @(posedge clk);
    if (rst_n) model_step();
    if (seen_start && stub_cnt == 0) stub_cnt = frame_len;
    else if (stub_cnt > 0) stub_cnt--;
    nb = (stub_cnt > 0) || hold_busy;
    nd = (stub_cnt == 1) || inject_done;
    #2;
    tx_busy = nb;
    tx_done = nd;
  endtask

  task automatic peek();
    #4;
  endtask

  task automatic wait_idle(input int max);
    int k;
    k = 0;
    while (!(m_phase == 0 && mq.size() == 0 && stub_cnt == 0 && !tx_busy) && k < max) begin
      tick();
      k++;
    end
    n_vec++;
    if (k >= max) begin
      n_err++;
      $display("FAIL idle_timeout: waited %0d cycles, limit %0d", k, max);
    end
  endtask

  task automatic push_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      valid = 1'b1;
      data = base + 8'(i);
      tick();
    end
    valid = 1'b0;
  endtask

  initial begin
    int peak;
    int k;
    rst_n = 1'b0; valid = 1'b0; data = 8'h00; flush = 1'b0;
    tx_busy = 1'b0; tx_done = 1'b0;
    model_reset();
    repeat (3) tick();
    peek();
    chk("rst_count", int'(count), 0);
    chk("rst_data", int'(tx_data), 8'h00);
    chk("rst_ready", int'(ready), 1);
    chk("rst_idle", int'(idle), 1);

    // single byte latency: push in cycle 0, start in cycle 2
    rst_n = 1'b1;
    valid = 1'b1; data = 8'hA5;
    tick();
    valid = 1'b0;
    peek();
    chk("a5_count_c1", int'(count), 1);
    chk("a5_start_c1", int'(tx_start), 0);
    tick();
    peek();
    chk("a5_start_c2", int'(tx_start), 1);
    chk("a5_data_c2", int'(tx_data), 8'hA5);
    wait_idle(200);

    // three bytes back to back
    cap_q.delete();
    frame_len = 4;
    peak = 0;
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1; data = 8'(i + 1);
      tick();
      peek();
      if (int'(count) > peak) peak = int'(count);
    end
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      peek();
      if (int'(count) > peak) peak = int'(count);
    end
    wait_idle(200);
    chk("b2b_peak", peak, 2);
    chk("b2b_starts", cap_q.size(), 3);
    for (int i = 0; i < cap_q.size(); i++) chk("b2b_order", int'(cap_q[i]), i + 1);
    peek();
    chk("b2b_idle", int'(idle), 1);

    // fill past full while busy, drain, twice to wrap the pointers
    for (int pass = 0; pass < 2; pass++) begin
      logic [7:0] base;
      base = (pass == 0) ? 8'h10 : 8'h80;
      cap_q.delete();
      hold_busy = 1'b1;
      tick();
      push_bytes(base, DEPTH + 2);
      peek();
      chk("fill_count", int'(count), 16);
      chk("fill_full", int'(full), 1);
      chk("fill_ready", int'(ready), 0);
      hold_busy = 1'b0;
      wait_idle(2000);
      chk("fill_drained", cap_q.size(), DEPTH);
      for (int i = 0; i < cap_q.size(); i++) chk("fill_order", int'(cap_q[i]), int'(base) + i);
    end

    // flush with 5 queued during a long frame, concurrent push
    cap_q.delete();
    frame_len = 30;
    push_bytes(8'h31, 6);
    k = 0;
    while (m_phase != 3 && k < 50) begin tick(); k++; end
    chk("flush_in_wait_done", m_phase, 3);
    chk("flush_queued", int'(count), 5);
    flush = 1'b1; valid = 1'b1; data = 8'hEE;
    tick();
    flush = 1'b0; valid = 1'b0;
    peek();
    chk("flush_count", int'(count), 0);
    wait_idle(200);
    chk("flush_starts", cap_q.size(), 1);
    chk("flush_inflight", int'(cap_q[0]), 8'h31);

    // reset during WAIT_BUSY with transmitter kept busy
    cap_q.delete();
    frame_len = 20;
    push_bytes(8'h41, 3);
    k = 0;
    while (m_phase != 2 && k < 50) begin tick(); k++; end
    chk("rst_mid_phase", m_phase, 2);
    rst_n = 1'b0;
    hold_busy = 1'b1;
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (98) tick();
    peek();
    chk("rst_mid_empty", int'(empty), 1);
    valid = 1'b1; data = 8'h7E;
    tick();
    valid = 1'b0;
    repeat (20) tick();
    chk("rst_mid_withheld", cap_q.size(), 1);
    hold_busy = 1'b0;
    tick();
    peek();
    chk("rst_7e_start_b", int'(tx_start), 0);
    tick();
    peek();
    chk("rst_7e_start_b1", int'(tx_start), 1);
    chk("rst_7e_data", int'(tx_data), 8'h7E);
    wait_idle(200);

    // stray done in IDLE plus push/pop at count 1
    cap_q.delete();
    frame_len = 3;
    hold_busy = 1'b1;
    tick();
    valid = 1'b1; data = 8'h51;
    tick();
    valid = 1'b0; hold_busy = 1'b0; inject_done = 1'b1;
    tick();
    inject_done = 1'b0;
    valid = 1'b1; data = 8'h52;
    tick();
    valid = 1'b0;
    peek();
    chk("pp_count", int'(count), 1);
    wait_idle(200);
    chk("pp_starts", cap_q.size(), 2);
    if (cap_q.size() == 2) begin
      chk("pp_first", int'(cap_q[0]), 8'h51);
      chk("pp_second", int'(cap_q[1]), 8'h52);
    end

    // random traffic
    for (int c = 0; c < 600; c++) begin
      valid = ($urandom_range(0, 2) != 0);
      data = 8'($urandom_range(0, 255));
      flush = ($urandom_range(0, 39) == 0);
      frame_len = $urandom_range(2, 6);
      hold_busy = ($urandom_range(0, 19) == 0);
      inject_done = ($urandom_range(0, 49) == 0);
      tick();
    end
    valid = 1'b0; flush = 1'b0; hold_busy = 1'b0; inject_done = 1'b0;
    wait_idle(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
